// File: rtl/dma_ctrl.sv
// Block-copy DMA controller for the 6502 bus at F200-F207.
// Stalls the CPU via rdy, copies LEN bytes SRC->DST, then leaves the bus idle one cycle for the CPU re-read.
module dma_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        rdy,
    output logic        irq,
    output logic        dma_own,
    output logic [15:0] dma_ab,
    output logic        dma_we,
    output logic [7:0]  dma_do,
    input  logic [7:0]  dma_di
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    localparam logic [2:0] REG_SRC_L  = 3'd0;
    localparam logic [2:0] REG_SRC_H  = 3'd1;
    localparam logic [2:0] REG_DST_L  = 3'd2;
    localparam logic [2:0] REG_DST_H  = 3'd3;
    localparam logic [2:0] REG_LEN_L  = 3'd4;
    localparam logic [2:0] REG_LEN_H  = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_STATUS = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD      = 2'd1,
        S_WR      = 2'd2,
        S_RESTORE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] src, src_n, dst, dst_n, len, len_n;
    logic          ie, ie_n, src_fix, src_fix_n, dst_fix, dst_fix_n, done, done_n;
    logic          reg_wr, start;
    logic          rdy_n, irq_n, own_n, we_n;
    logic [AW-1:0] ab_n;
    logic [DW-1:0] dout_n;

    assign reg_wr = cs & we & (state == S_IDLE);
    assign start  = reg_wr & (addr == REG_CTRL) & din[0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start && len != '0) state_n = S_RD;
            S_RD:      state_n = S_WR;
            S_WR:      state_n = (len == AW'(1)) ? S_RESTORE : S_RD;
            S_RESTORE: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Register file and pointer updates
    always_comb begin
        src_n     = src;
        dst_n     = dst;
        len_n     = len;
        ie_n      = ie;
        src_fix_n = src_fix;
        dst_fix_n = dst_fix;
        done_n    = done;
        if (reg_wr) begin
            case (addr)
                REG_SRC_L: src_n[7:0]  = din;
                REG_SRC_H: src_n[15:8] = din;
                REG_DST_L: dst_n[7:0]  = din;
                REG_DST_H: dst_n[15:8] = din;
                REG_LEN_L: len_n[7:0]  = din;
                REG_LEN_H: len_n[15:8] = din;
                REG_CTRL: begin
                    ie_n      = din[1];
                    dst_fix_n = din[2];
                    src_fix_n = din[3];
                    if (din[7] || din[0]) done_n = 1'b0;
                    // A zero-length start completes immediately
                    if (din[0] && len == '0) done_n = 1'b1;
                end
                default: ;
            endcase
        end
        if (state == S_WR) begin
            src_n = src + {{(AW-1){1'b0}}, ~src_fix};
            dst_n = dst + {{(AW-1){1'b0}}, ~dst_fix};
            len_n = len - AW'(1);
        end
        if (state == S_RESTORE) done_n = 1'b1;
    end

    // Output logic, evaluated on the next state so the outputs can be registered
    always_comb begin
        rdy_n = 1'b1;
        own_n = 1'b0;
        we_n  = 1'b0;
        ab_n  = '0;
        case (state_n)
            S_RD: begin
                rdy_n = 1'b0;
                own_n = 1'b1;
                ab_n  = src_n;
            end
            S_WR: begin
                rdy_n = 1'b0;
                own_n = 1'b1;
                we_n  = 1'b1;
                ab_n  = dst_n;
            end
            S_RESTORE: rdy_n = 1'b0;
            default: ;
        endcase
        irq_n  = done_n & ie_n;
        dout_n = dout;
        if (cs && !we) begin
            case (addr)
                REG_SRC_L:  dout_n = src[7:0];
                REG_SRC_H:  dout_n = src[15:8];
                REG_DST_L:  dout_n = dst[7:0];
                REG_DST_H:  dout_n = dst[15:8];
                REG_LEN_L:  dout_n = len[7:0];
                REG_LEN_H:  dout_n = len[15:8];
                REG_CTRL:   dout_n = {4'b0, src_fix, dst_fix, ie, 1'b0};
                REG_STATUS: dout_n = {(state != S_IDLE), done, 6'b0};
                default:    dout_n = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            ie      <= 1'b0;
            src_fix <= 1'b0;
            dst_fix <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
            rdy     <= 1'b1;
            irq     <= 1'b0;
            dma_own <= 1'b0;
            dma_we  <= 1'b0;
            dma_ab  <= '0;
        end else begin
            src     <= src_n;
            dst     <= dst_n;
            len     <= len_n;
            ie      <= ie_n;
            src_fix <= src_fix_n;
            dst_fix <= dst_fix_n;
            done    <= done_n;
            dout    <= dout_n;
            rdy     <= rdy_n;
            irq     <= irq_n;
            dma_own <= own_n;
            dma_we  <= we_n;
            dma_ab  <= ab_n;
        end
    end

    // The byte read in RD arrives on dma_di during WR and is forwarded directly
    assign dma_do = dma_we ? dma_di : '0;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed and randomized bench for dma_ctrl with a bus-side RAM and a byte-level copy model.
module tb_dma_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [7:0]  din = 8'd0;
    logic [7:0]  dout;
    logic        rdy, irq, dma_own, dma_we;
    logic [15:0] dma_ab;
    logic [7:0]  dma_do;
    logic [7:0]  di_q;

    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'd0;
    logic [7:0]  pl_data = 8'd0;

    logic [7:0]  mem   [0:65535];
    logic [7:0]  model [0:65535];

    int errors = 0;
    int checks = 0;

    dma_ctrl dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din),
        .dout(dout), .rdy(rdy), .irq(irq), .dma_own(dma_own), .dma_ab(dma_ab),
        .dma_we(dma_we), .dma_do(dma_do), .dma_di(di_q)
    );

    always #5 clk = ~clk;

    // RAM: read data one cycle after the address, writes from preload port or DMA
    always @(posedge clk) begin
        di_q <= mem[dma_ab];
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (dma_own && dma_we) mem[dma_ab] <= dma_do;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        cs = 1'b0;
        d = dout;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        model[a] = d;
    endtask

    task automatic chk16(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [7:0] lo, hi;
        rd(a, lo);
        rd(a + 3'd1, hi);
        chk(tag, {16'd0, hi, lo}, {16'd0, exp});
    endtask

    // Program and run one transfer, checking bus activity cycle by cycle against the model
    task automatic xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                        input bit sf, input bit df, input bit ie_b);
        int rl, ol, k;
        bit ok;
        logic [15:0] sa, da;
        logic [7:0] st;
        wr(3'd0, s[7:0]);  wr(3'd1, s[15:8]);
        wr(3'd2, d[7:0]);  wr(3'd3, d[15:8]);
        wr(3'd4, 8'(n));   wr(3'd5, 8'(n >> 8));
        wr(3'd6, {4'b0, sf, df, ie_b, 1'b1});
        rl = 0; ol = 0; ok = 1'b0;
        for (int c = 0; c < 2 * n + 10; c++) begin
            if (rdy) begin ok = 1'b1; break; end
            rl++;
            if (dma_own) ol++;
            if (c < 2 * n) begin
                k  = c / 2;
                sa = 16'(s + (sf ? 0 : k));
                da = 16'(d + (df ? 0 : k));
                if (c % 2 == 0) begin
                    chk($sformatf("rd_ab[%0d]", k), {16'd0, dma_ab}, {16'd0, sa});
                    chk($sformatf("rd_we[%0d]", k), {31'd0, dma_we}, 32'd0);
                end else begin
                    chk($sformatf("wr_ab[%0d]", k), {16'd0, dma_ab}, {16'd0, da});
                    chk($sformatf("wr_do[%0d]", k), {24'd0, dma_do}, {24'd0, model[sa]});
                    model[da] = model[sa];
                end
            end
            @(posedge clk); #1;
        end
        chk("xfer_timeout", {31'd0, ok}, 32'd1);
        chk("rdy_low_cycles", rl, 2 * n + 1);
        chk("own_cycles", ol, 2 * n);
        chk("irq_after", {31'd0, irq}, {31'd0, ie_b});
        rd(3'd7, st);
        chk("status_after", {24'd0, st}, 32'h40);
        chk16("src_final", 3'd0, 16'(s + (sf ? 0 : n)));
        chk16("dst_final", 3'd2, 16'(d + (df ? 0 : n)));
        chk16("len_final", 3'd4, 16'd0);
        for (int i = 0; i < n; i++) begin
            da = 16'(d + (df ? 0 : i));
            chk($sformatf("mem[%04h]", da), {24'd0, mem[da]}, {24'd0, model[da]});
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [15:0] s, d;
        int n;
        bit sf, df, ieb, stayed;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_own", {31'd0, dma_own}, 32'd0);
        chk("rst_we", {31'd0, dma_we}, 32'd0);
        chk("rst_ab", {16'd0, dma_ab}, 32'd0);
        chk("rst_do", {24'd0, dma_do}, 32'd0);
        reset = 1'b0;

        // Basic copy with interrupt enabled
        preload(16'h0200, 8'h11); preload(16'h0201, 8'h22);
        preload(16'h0202, 8'h33); preload(16'h0203, 8'h44);
        xfer(16'h0200, 16'h0300, 4, 1'b0, 1'b0, 1'b1);
        chk("basic_b3", {24'd0, mem[16'h0303]}, 32'h44);
        rd(3'd6, v);
        chk("ctrl_read", {24'd0, v}, 32'h02);

        // Done clear with ie kept set
        wr(3'd6, 8'h82);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        rd(3'd7, v);
        chk("status_cleared", {24'd0, v}, 32'h00);

        // Fill mode
        preload(16'h0010, 8'hA5);
        xfer(16'h0010, 16'h1000, 256, 1'b1, 1'b0, 1'b0);
        chk("fill_last", {24'd0, mem[16'h10FF]}, 32'hA5);

        // Source pointer wrap, ie=0 keeps irq low while done
        preload(16'hFFFE, 8'h01); preload(16'hFFFF, 8'h02); preload(16'h0000, 8'h03);
        xfer(16'hFFFE, 16'h5000, 3, 1'b0, 1'b0, 1'b0);
        chk("wrap_b2", {24'd0, mem[16'h5002]}, 32'h03);

        // Zero length
        wr(3'd4, 8'h00); wr(3'd5, 8'h00);
        wr(3'd6, 8'h03);
        chk("zl_rdy", {31'd0, rdy}, 32'd1);
        chk("zl_own", {31'd0, dma_own}, 32'd0);
        stayed = 1'b1;
        cs = 1'b1; we = 1'b0; addr = 3'd7;
        @(posedge clk); #1;
        cs = 1'b0;
        if (!rdy || dma_own) stayed = 1'b0;
        chk("zl_status", {24'd0, dout}, 32'h40);
        repeat (4) begin
            @(posedge clk); #1;
            if (!rdy || dma_own) stayed = 1'b0;
        end
        chk("zl_quiet", {31'd0, stayed}, 32'd1);
        chk("zl_irq", {31'd0, irq}, 32'd1);

        // Randomized transfers
        for (int t = 0; t < 6; t++) begin
            s   = 16'(32'h2000 + $urandom_range(0, 4095));
            d   = 16'(32'h6000 + $urandom_range(0, 4095));
            n   = int'($urandom_range(1, 12));
            sf  = 1'($urandom_range(0, 1));
            df  = 1'($urandom_range(0, 1));
            ieb = 1'($urandom_range(0, 1));
            for (int i = 0; i < (sf ? 1 : n); i++) preload(16'(s + i), 8'($urandom));
            xfer(s, d, n, sf, df, ieb);
        end

        // Reset during a long transfer
        for (int i = 0; i < 100; i++) begin
            preload(16'(32'h3000 + i), 8'(i + 1));
            preload(16'(32'h4000 + i), 8'h5A);
        end
        wr(3'd0, 8'h00); wr(3'd1, 8'h30);
        wr(3'd2, 8'h00); wr(3'd3, 8'h40);
        wr(3'd4, 8'd100); wr(3'd5, 8'h00);
        wr(3'd6, 8'h03);
        repeat (20) begin @(posedge clk); #1; end
        chk("mid_own", {31'd0, dma_own}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mr_rdy", {31'd0, rdy}, 32'd1);
        chk("mr_own", {31'd0, dma_own}, 32'd0);
        chk("mr_we", {31'd0, dma_we}, 32'd0);
        chk("mr_ab", {16'd0, dma_ab}, 32'd0);
        chk("mr_irq", {31'd0, irq}, 32'd0);
        chk("mr_dout", {24'd0, dout}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            chk($sformatf("mr_reg%0d", a), {24'd0, v}, 32'd0);
        end
        for (int i = 0; i < 100; i++)
            chk($sformatf("mr_mem[%0d]", i), {24'd0, mem[16'(32'h4000 + i)]},
                (i < 10) ? 32'(i + 1) : 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
